// File: rtl/byte_word_packer.sv
// byte_word_packer
//
// Packs an 8-bit byte stream little-endian into 32-bit words. The first
// byte of a word lands in lane 0 (bits [7:0]). A word is complete after
// four bytes, or earlier when it is flushed. Completed words go into a
// DEPTH-entry FIFO. The FIFO head is presented on a valid/ready word
// interface, and each word carries per-lane keep flags.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   byte_data   incoming byte
//   byte_valid  byte_data is valid this cycle
//   byte_ready  packer can take a byte or a flush this cycle
//   flush       close the current partial word (qualified by byte_ready)
//   word_data   head FIFO word, lane k = bits [8k+7:8k]; 0 when empty
//   word_keep   lane-valid flags for word_data; 0 when empty
//   word_valid  FIFO not empty
//   word_ready  downstream accepts the head word
//   fifo_level  number of words currently buffered
//
// DEPTH must be a power of two and at least 2, so the pointers can wrap
// naturally.

// One assembly lane: holds a byte and its keep bit. The lane also exposes
// the merged view (stored value plus any write this cycle), which is what
// gets pushed when the word closes on the same edge.
module byte_word_packer_lane (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       clr,
    input  logic [7:0] byte_in,
    output logic [7:0] lane_data,
    output logic       lane_keep
);
    logic [7:0] data_q, data_d;
    logic       keep_q, keep_d;

    always_comb begin
        lane_data = data_q;
        lane_keep = keep_q;
        if (wr_en) begin
            lane_data = byte_in;
            lane_keep = 1'b1;
        end
        data_d = lane_data;
        keep_d = lane_keep;
        // A push consumes the merged value, so the lane restarts empty.
        if (clr) begin
            data_d = 8'h00;
            keep_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= 8'h00;
            keep_q <= 1'b0;
        end else begin
            data_q <= data_d;
            keep_q <= keep_d;
        end
    end
endmodule

module byte_word_packer #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             byte_data,
    input  logic                   byte_valid,
    output logic                   byte_ready,
    input  logic                   flush,
    output logic [31:0]            word_data,
    output logic [3:0]             word_keep,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int NUM_LANES = 4;
    localparam int PW        = $clog2(DEPTH);
    localparam int LW        = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [1:0]    idx_q, idx_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [35:0]   mem_q [DEPTH];
    logic [35:0]   mem_d [DEPTH];

    logic byte_fire, flush_fire, push, pop;
    logic [NUM_LANES-1:0][7:0] merged_data;
    logic [NUM_LANES-1:0]      merged_keep;
    logic [35:0]               head;

    // byte_ready depends only on registered state. There is no
    // combinational path from word_ready, so a push is never attempted
    // into a full FIFO.
    assign byte_ready = (level_q != FULL_LVL);
    assign byte_fire  = byte_valid && byte_ready;
    assign flush_fire = flush && byte_ready;
    assign pop        = word_valid && word_ready;

    // The assembly register is non-empty exactly when idx != 0, unless a
    // byte arrives this cycle. A flush with nothing to close does nothing.
    assign push = (byte_fire && (idx_q == 2'd3)) ||
                  (flush_fire && (byte_fire || (idx_q != 2'd0)));

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        byte_word_packer_lane u_lane (
            .clk       (clk),
            .reset     (reset),
            .wr_en     (byte_fire && (idx_q == 2'(k))),
            .clr       (push),
            .byte_in   (byte_data),
            .lane_data (merged_data[k]),
            .lane_keep (merged_keep[k])
        );
    end

    always_comb begin
        idx_d = idx_q;
        if (push)
            idx_d = 2'd0;
        else if (byte_fire)
            idx_d = idx_q + 2'd1;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            // Lanes not written since the last push are still zero.
            mem_d[wr_ptr_q] = {merged_keep, merged_data};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q    <= 2'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            idx_q    <= idx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            mem_q    <= mem_d;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign word_valid = (level_q != '0);
    // Stale entries stay in storage after a pop, so the outputs are masked
    // to zero whenever the FIFO is empty.
    assign word_data  = word_valid ? head[31:0]  : 32'h0;
    assign word_keep  = word_valid ? head[35:32] : 4'h0;
    assign fifo_level = level_q;
endmodule

// File: tb/tb_byte_word_packer.sv
module tb_byte_word_packer;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        flush;
    logic [31:0] word_data;
    logic [3:0]  word_keep;
    logic        word_valid;
    logic        word_ready;
    logic [2:0]  fifo_level;

    int checks   = 0;
    int failures = 0;

    byte_word_packer #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .flush      (flush),
        .word_data  (word_data),
        .word_keep  (word_keep),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input logic [31:0] d, input logic [3:0] k,
                            input logic [2:0] lvl);
        chk({tag, ".valid"}, 36'(word_valid), 36'(1));
        chk({tag, ".data"},  36'(word_data),  36'(d));
        chk({tag, ".keep"},  36'(word_keep),  36'(k));
        chk({tag, ".level"}, 36'(fifo_level), 36'(lvl));
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".valid"}, 36'(word_valid), 36'(0));
        chk({tag, ".data"},  36'(word_data),  36'(0));
        chk({tag, ".keep"},  36'(word_keep),  36'(0));
        chk({tag, ".level"}, 36'(fifo_level), 36'(0));
        chk({tag, ".ready"}, 36'(byte_ready), 36'(1));
    endtask

    task automatic send(input logic [7:0] b);
        byte_data  = b;
        byte_valid = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0; byte_data = 8'h00; byte_valid = 1'b0;
        flush = 1'b0; word_ready = 1'b0;
        #2;
        chk_empty("reset");
        #10;
        reset = 1'b1;

        // Full word, no backpressure
        word_ready = 1'b1;
        send(8'h11); chk("t1.v0", 36'(word_valid), 36'(0));
        send(8'h22);
        send(8'h33); chk("t1.v2", 36'(word_valid), 36'(0));
        send(8'h44);
        chk_word("t1.word", 32'h44332211, 4'hF, 3'd1);
        byte_valid = 1'b0;
        tick();
        chk_empty("t1.drain");

        // Partial flush, then a flush with nothing assembled
        send(8'hAA); send(8'hBB);
        byte_valid = 1'b0; flush = 1'b1;
        tick();
        chk_word("t2.word", 32'h0000BBAA, 4'h3, 3'd1);
        tick();
        chk_empty("t2.noflush");
        flush = 1'b0;

        // Flush together with the third byte
        send(8'hAA); send(8'hBB);
        flush = 1'b1;
        send(8'hCC);
        chk_word("t3.word", 32'h00CCBBAA, 4'h7, 3'd1);
        flush = 1'b0;
        send(8'hDD);
        chk("t3.drain", 36'(fifo_level), 36'(0));
        flush = 1'b1;
        send(8'hEE);
        chk_word("t3.idx0", 32'h0000EEDD, 4'h3, 3'd1);
        flush = 1'b0; byte_valid = 1'b0;
        tick();
        chk_empty("t3.end");

        // Backpressure: 16 bytes into a stalled FIFO
        word_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(8'(8'h40 + i));
        chk_word("t4.full", 32'h43424140, 4'hF, 3'd4);
        chk("t4.ready0", 36'(byte_ready), 36'(0));
        byte_data = 8'hEE; byte_valid = 1'b1;
        tick(); tick();
        chk_word("t4.stall", 32'h43424140, 4'hF, 3'd4);
        chk("t4.ready1", 36'(byte_ready), 36'(0));
        word_ready = 1'b1;
        tick();
        chk_word("t4.pop1", 32'h47464544, 4'hF, 3'd3);
        chk("t4.ready2", 36'(byte_ready), 36'(1));
        tick();
        chk_word("t4.pop2", 32'h4B4A4948, 4'hF, 3'd2);
        byte_valid = 1'b0;
        tick();
        chk_word("t4.pop3", 32'h4F4E4D4C, 4'hF, 3'd1);
        tick();
        chk("t4.empty", 36'(word_valid), 36'(0));
        flush = 1'b1;
        tick();
        chk_word("t4.held", 32'h000000EE, 4'h1, 3'd1);
        flush = 1'b0;
        tick();
        chk_empty("t4.end");

        // Simultaneous push and pop at level 2
        word_ready = 1'b0;
        for (int i = 0; i < 11; i++) send(8'(8'h50 + i));
        chk_word("t5.lvl2", 32'h53525150, 4'hF, 3'd2);
        word_ready = 1'b1;
        send(8'h5B);
        chk_word("t5.pushpop", 32'h57565554, 4'hF, 3'd2);
        byte_valid = 1'b0;
        tick();
        chk_word("t5.next", 32'h5B5A5958, 4'hF, 3'd1);
        tick();
        chk_empty("t5.end");

        // Reset with 3 words buffered and 2 bytes assembled
        word_ready = 1'b0;
        for (int i = 0; i < 14; i++) send(8'(8'h60 + i));
        chk_word("t6.pre", 32'h63626160, 4'hF, 3'd3);
        byte_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk_empty("t6.rst");
        #1;
        reset = 1'b1;
        word_ready = 1'b1;
        send(8'h01); send(8'h02); send(8'h03);
        chk("t6.nothing", 36'(word_valid), 36'(0));
        send(8'h04);
        chk_word("t6.fresh", 32'h04030201, 4'hF, 3'd1);
        byte_valid = 1'b0;
        tick();
        chk_empty("t6.end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/byte_word_packer.md
# byte_word_packer

Downstream consumer of the 8-bit byte stream produced by the byte-datapath stage. Each accepted byte is packed little-endian into a 32-bit word. Completed or flushed words are buffered in a small FIFO and presented on a valid/ready word interface with per-byte keep flags. Backpressure reaches the byte side through `byte_ready`.

## Interface
- `DEPTH`, default 4: word FIFO entries; must be a power of two, ≥ 2.
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `byte_data`  input  8  incoming byte.
- `byte_valid`  input  1  `byte_data` is valid this cycle.
- `byte_ready`  output  1  packer can accept a byte or flush this cycle.
- `flush`  input  1  close the current partial word; qualified by `byte_ready`.
- `word_data`  output  32  head FIFO word; lane k = bits [8k+7:8k].
- `word_keep`  output  4  lane-valid flags for `word_data`.
- `word_valid`  output  1  FIFO is not empty.
- `word_ready`  input  1  downstream accepts the head word.
- `fifo_level`  output  $clog2(DEPTH)+1  number of words currently stored.

## Operation
**Definitions**
- `byte_fire` = `byte_valid` && `byte_ready`.
- `flush_fire` = `flush` && `byte_ready`.
- `pop` = `word_valid` && `word_ready`.

**Lane index `idx`** (0..3, 2 bits)
- On `byte_fire`, `byte_data` is written into assembly lane `idx` and the matching keep bit is set.
- `idx` then increments, wrapping 3→0.

**Word completion (push)**
- A word is pushed when `byte_fire` occurs at `idx` = 3, or when `flush_fire` occurs with the assembly register non-empty.
- Push contents:
  - `byte_fire` at `idx` = 3: full word, keep = 4'b1111.
  - `flush_fire` with `byte_fire`: the byte is included first; keep covers lanes 0..`idx`.
  - `flush_fire` alone with `idx` > 0: keep covers lanes 0..`idx`-1.
- Unused lanes are pushed as 8'h00.
- After a push, `idx` = 0 and the assembly register and keep bits are cleared.
- `flush_fire` with `idx` = 0 and no `byte_fire` is a no-op: no empty word is ever pushed.

**Backpressure**
- `byte_ready` = (`fifo_level` != `DEPTH`).
- It is a function of registered state only; there is no combinational path from `word_ready` to `byte_ready`.
- When the FIFO is full, both bytes and flush stall. The source holds `byte_valid`, `byte_data` and `flush` stable until `byte_ready`.

**FIFO**
- Storage: `DEPTH` entries × 36 bits, with read/write pointers of `$clog2(DEPTH)` bits that wrap naturally.
- A push and a pop in the same cycle are both performed and `fifo_level` is unchanged.
- A pop on an empty FIFO is impossible because `word_valid` is 0.
- `word_data` and `word_keep` show the head entry while `word_valid` = 1, and read as 0 when the FIFO is empty.

**Reset**
- `reset` low clears, immediately and asynchronously: `idx`, the assembly register, keep bits, pointers and `fifo_level`.
- Reset values: `word_valid` = 0, `word_data` = 0, `word_keep` = 0, `fifo_level` = 0, `byte_ready` = 1.
- Reset mid-word or with a non-empty FIFO discards all partial and buffered data without emitting it.

## Timing
- Latency: a word completed by a push at rising edge N drives `word_valid` = 1 with that word from just after edge N, provided the FIFO was empty.
- Throughput: one byte per cycle sustained, i.e. one word every 4 cycles, while `word_ready` is held high. The FIFO never fills in this case.
- `fifo_level` and `byte_ready` update on the edge following a push or pop.
- The pop at edge N reveals the next head entry immediately after edge N.
- Reset deassertion is synchronised externally; the first `byte_fire` may occur on the first edge with `reset` high.

## Test plan
- **Full word, no backpressure:** after reset, send bytes 8'h11, 8'h22, 8'h33, 8'h44 on consecutive cycles with `word_ready` = 1 → one word 32'h44332211 with keep 4'hF, `word_valid` high for exactly one cycle, `fifo_level` returns to 0.
- **Partial flush:** send 8'hAA, 8'hBB, then `flush` alone → word 32'h0000BBAA with keep 4'h3. A following `flush` with no bytes → no push.
- **Flush with byte:** `flush` together with the third byte 8'hCC after 8'hAA, 8'hBB → word 32'h00CCBBAA, keep 4'h7, `idx` back to 0.
- **Backpressure:** hold `word_ready` = 0 and stream 4×`DEPTH` = 16 bytes → `fifo_level` reaches 4 and `byte_ready` drops. Then release `word_ready` → four words emerge in order, `byte_ready` rises one cycle after the first pop, and no byte is lost or duplicated.
- **Simultaneous push and pop:** with `fifo_level` = 2, complete a word in the same cycle as a pop → `fifo_level` stays 2 and ordering is preserved.
- **Reset mid-operation:** pull `reset` low with 2 bytes assembled and 3 words buffered → outputs go to reset values immediately. After release, a fresh 4-byte word 32'h04030201 emerges alone.
